// File: rtl/axis_burst_gen_if.sv
// Command handshake and AXI-Stream master bundle for axis_burst_gen.
// The master modport is the generator's view; slave is the consumer/commander side.
interface axis_burst_gen_if #(
   parameter int unsigned DATA_BYTES = 8,
   parameter int unsigned LEN_W      = 16
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [LEN_W-1:0]        cmd_len;
   logic [7:0]              cmd_seed;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic [8*DATA_BYTES-1:0] m_axis_tdata;
   logic [DATA_BYTES-1:0]   m_axis_tkeep;
   logic                    m_axis_tlast;

   modport master (
      input  cmd_valid,
      output cmd_ready,
      input  cmd_len,
      input  cmd_seed,
      output m_axis_tvalid,
      input  m_axis_tready,
      output m_axis_tdata,
      output m_axis_tkeep,
      output m_axis_tlast
   );

   modport slave (
      output cmd_valid,
      input  cmd_ready,
      output cmd_len,
      output cmd_seed,
      input  m_axis_tvalid,
      output m_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tkeep,
      input  m_axis_tlast
   );
endinterface

// File: rtl/axis_burst_gen.sv
// Packet-forming stage: turns a (length, seed) command into AXI-Stream beats carrying an
// incrementing byte pattern, with a right-aligned tkeep mask on the final beat.
module axis_burst_gen #(
   parameter int unsigned DATA_BYTES = 8,
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   axis_burst_gen_if.master bus,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt
);
   typedef enum logic [0:0] {StIdle, StSend} state_e;

   localparam logic [LEN_W-1:0] BeatLen = LEN_W'(DATA_BYTES);

   state_e state;
   logic [LEN_W-1:0] rem;
   logic [7:0]       b;

   logic                    accept;
   logic [LEN_W-1:0]        src_rem;
   logic [7:0]              src_b;
   logic [8*DATA_BYTES-1:0] src_data;
   logic [DATA_BYTES-1:0]   src_keep;
   logic                    src_last;

   // Sets every bit at or below the highest set bit of x.
   function automatic logic [DATA_BYTES-1:0] get_thermo_left(input logic [DATA_BYTES-1:0] x);
      logic [DATA_BYTES-1:0] t;
      t[DATA_BYTES-1] = x[DATA_BYTES-1];
      for (int i = int'(DATA_BYTES) - 2; i >= 0; i--) begin
         t[i] = t[i+1] | x[i];
      end
      return t;
   endfunction

   assign accept = (state == StIdle) && bus.cmd_valid && (bus.cmd_len != '0);
   assign busy   = (state == StSend);

   // Next beat comes either from a fresh command or from advancing the current one.
   always_comb begin
      src_rem  = accept ? bus.cmd_len : rem - BeatLen;
      src_b    = accept ? bus.cmd_seed : b + 8'(DATA_BYTES);
      src_data = '0;
      for (int j = 0; j < int'(DATA_BYTES); j++) begin
         src_data[8*j +: 8] = src_b + 8'(j);
      end
      src_last = (src_rem <= BeatLen);
      if (src_rem >= BeatLen) begin
         src_keep = '1;
      end else begin
         src_keep = get_thermo_left({{(DATA_BYTES-1){1'b0}}, 1'b1} << (src_rem - 1'b1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= StIdle;
         rem               <= '0;
         b                 <= '0;
         bus.cmd_ready     <= 1'b1;
         bus.m_axis_tvalid <= 1'b0;
         bus.m_axis_tdata  <= '0;
         bus.m_axis_tkeep  <= '0;
         bus.m_axis_tlast  <= 1'b0;
         pkt_cnt           <= '0;
      end else begin
         case (state)
            StIdle: begin
               // Zero-length commands are consumed here with no effect.
               if (accept) begin
                  rem               <= src_rem;
                  b                 <= src_b;
                  bus.m_axis_tdata  <= src_data;
                  bus.m_axis_tkeep  <= src_keep;
                  bus.m_axis_tlast  <= src_last;
                  bus.m_axis_tvalid <= 1'b1;
                  bus.cmd_ready     <= 1'b0;
                  state             <= StSend;
               end
            end
            StSend: begin
               if (bus.m_axis_tready) begin
                  if (bus.m_axis_tlast) begin
                     bus.m_axis_tvalid <= 1'b0;
                     bus.cmd_ready     <= 1'b1;
                     pkt_cnt           <= pkt_cnt + CNT_W'(1);
                     state             <= StIdle;
                  end else begin
                     rem              <= src_rem;
                     b                <= src_b;
                     bus.m_axis_tdata <= src_data;
                     bus.m_axis_tkeep <= src_keep;
                     bus.m_axis_tlast <= src_last;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_burst_gen.sv
// Self-checking bench for axis_burst_gen: directed and randomized packets against a
// byte-stream reference model.
module tb_axis_burst_gen;
   localparam int DB = 8;

   logic        clk;
   logic        reset_n;
   logic        busy;
   logic [15:0] pkt_cnt;

   int compared;
   int mismatched;
   int exp_cnt;

   axis_burst_gen_if #(.DATA_BYTES(DB), .LEN_W(16)) bus ();

   axis_burst_gen #(.DATA_BYTES(DB), .LEN_W(16), .CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy),
      .pkt_cnt (pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Beat idx of a packet carries bytes seed+idx*DB .. seed+idx*DB+DB-1, mod 256.
   function automatic logic [63:0] exp_data(input int seed, input int idx);
      logic [63:0] d;
      d = '0;
      for (int j = 0; j < DB; j++) d[8*j +: 8] = 8'((seed + idx * DB + j) % 256);
      return d;
   endfunction

   function automatic logic [63:0] exp_keep(input int len, input int idx);
      int n;
      n = len - idx * DB;
      if (n >= DB) return 64'hFF;
      return 64'((1 << n) - 1);
   endfunction

   // Entered and left on a falling edge. hold keeps cmd_valid high with the next command.
   task automatic run_packet(input int len, input int seed, input int pct,
                             input bit hold, input int nlen, input int nseed);
      int beats;
      int i;
      int cyc;
      check("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 16'(len);
      bus.cmd_seed  = 8'(seed);
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         bus.cmd_len  = 16'(nlen);
         bus.cmd_seed = 8'(nseed);
      end else begin
         bus.cmd_valid = 1'b0;
      end
      if (len == 0) begin
         check("len0_tvalid", bus.m_axis_tvalid, 0);
         check("len0_cmd_ready", bus.cmd_ready, 1);
         check("len0_pkt_cnt", pkt_cnt, 64'(exp_cnt));
         return;
      end
      beats = (len + DB - 1) / DB;
      i = 0;
      cyc = 0;
      while (i < beats && cyc < beats * 40 + 40) begin
         bus.m_axis_tready = ($urandom_range(99) < pct);
         check("tvalid", bus.m_axis_tvalid, 1);
         check("tdata", bus.m_axis_tdata, exp_data(seed, i));
         check("tkeep", bus.m_axis_tkeep, exp_keep(len, i));
         check("tlast", bus.m_axis_tlast, (i == beats - 1) ? 1 : 0);
         check("cmd_ready_send", bus.cmd_ready, 0);
         check("busy_send", busy, 1);
         @(posedge clk);
         @(negedge clk);
         if (bus.m_axis_tready) i++;
         cyc++;
      end
      check("beat_budget", 64'(i), 64'(beats));
      bus.m_axis_tready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 65536;
      check("end_tvalid", bus.m_axis_tvalid, 0);
      check("end_busy", busy, 0);
      check("end_cmd_ready", bus.cmd_ready, 1);
      check("pkt_cnt", pkt_cnt, 64'(exp_cnt));
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      exp_cnt       = 0;
      reset_n       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_seed  = '0;
      bus.m_axis_tready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_tvalid", bus.m_axis_tvalid, 0);
      check("rst_tdata", bus.m_axis_tdata, 0);
      check("rst_tkeep", bus.m_axis_tkeep, 0);
      check("rst_tlast", bus.m_axis_tlast, 0);
      check("rst_busy", busy, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
      reset_n = 1'b1;
      @(negedge clk);

      run_packet(20, 8'h10, 100, 1'b0, 0, 0);
      run_packet(8, 8'hA0, 100, 1'b0, 0, 0);
      run_packet(1, 8'h3C, 100, 1'b0, 0, 0);
      run_packet(24, 8'hFE, 50, 1'b0, 0, 0);
      run_packet(0, 8'h11, 100, 1'b0, 0, 0);
      run_packet(16, 8'h20, 60, 1'b1, 9, 8'h40);
      run_packet(9, 8'h40, 100, 1'b0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         run_packet(int'($urandom_range(70, 1)), int'($urandom_range(255)),
                    int'($urandom_range(90, 30)), 1'b0, 0, 0);
      end
      run_packet(65535, 8'h33, 100, 1'b0, 0, 0);

      // Reset while beat 2 of a 40-byte packet is on the bus.
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 16'd40;
      bus.cmd_seed  = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.m_axis_tready = 1'b1;
      check("r_beat1", bus.m_axis_tdata, exp_data(8'h5A, 0));
      @(posedge clk);
      @(negedge clk);
      check("r_beat2", bus.m_axis_tdata, exp_data(8'h5A, 1));
      reset_n = 1'b0;
      #1;
      check("ar_tvalid", bus.m_axis_tvalid, 0);
      check("ar_tlast", bus.m_axis_tlast, 0);
      check("ar_tdata", bus.m_axis_tdata, 0);
      check("ar_tkeep", bus.m_axis_tkeep, 0);
      check("ar_busy", busy, 0);
      check("ar_cmd_ready", bus.cmd_ready, 1);
      check("ar_pkt_cnt", pkt_cnt, 0);
      exp_cnt = 0;
      bus.m_axis_tready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_packet(13, 8'h77, 70, 1'b0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/axis_burst_gen.md
Name: axis_burst_gen

Overview:
- Packet-forming stage of the AXI-Stream generator.
- Accepts a packet command (byte length plus seed) over a valid/ready handshake.
- Emits the packet on an AXI-Stream master as full-width beats carrying an incrementing byte pattern.
- On the final beat, tkeep is a right-aligned thermometer mask covering the remaining bytes, computed with the shared left-thermometer utility from `utils`. The result feeds the stream checker and the output mux.

Parameters:
- DATA_BYTES, 8, bytes per beat; tdata width is 8*DATA_BYTES, tkeep width is DATA_BYTES. Power of two, ≥ 2.
- LEN_W, 16, width of the byte-length field.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_len  in  LEN_W  packet length in bytes.
- cmd_seed  in  8  value of byte 0 of the packet.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  8*DATA_BYTES  payload; byte j occupies bits [8j+7:8j].
- m_axis_tkeep  out  DATA_BYTES  byte qualifiers.
- m_axis_tlast  out  1  final beat of the packet.
- busy  out  1  high while a packet is in flight.
- pkt_cnt  out  CNT_W  number of completed packets, wrapping.

Behaviour:
- Reset: async assert, clears all state. FSM goes to IDLE. cmd_ready=1, m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, busy=0, pkt_cnt=0. Deassertion is treated as synchronous to clk.
- FSM states:
  - IDLE: cmd_ready=1, tvalid=0.
  - SEND: cmd_ready=0, tvalid=1.
- Command accept (IDLE, cmd_valid=1):
  - cmd_len=0: command consumed, no output, stay in IDLE, pkt_cnt unchanged.
  - cmd_len>0: on that edge load rem=cmd_len and byte pointer b=cmd_seed, register the first beat, move to SEND. tvalid is high in the next cycle, so latency is 1 cycle from command handshake to first tvalid.
- Beat content (all outputs registered):
  - byte j = (b + j) mod 256.
  - tlast = (rem ≤ DATA_BYTES).
  - tkeep = all-ones if rem ≥ DATA_BYTES; otherwise the thermometer with bits [rem-1:0] set, via get_thermo_left(1 << (rem-1)).
  - Disabled byte lanes still carry the pattern value.
- Beat handshake (tvalid & tready):
  - Not last: rem -= DATA_BYTES, b += DATA_BYTES (mod 256), next beat loaded on the same edge. Sustained rate is 1 beat/cycle under tready=1.
  - Last: FSM returns to IDLE, tvalid=0 next cycle, pkt_cnt += 1 (wraps at 2^CNT_W).
  - Packets therefore have a minimum 1-cycle gap between them.
- Backpressure:
  - While tvalid & !tready, tdata/tkeep/tlast hold stable.
  - tvalid never deasserts without a handshake.
  - cmd_ready stays 0 throughout SEND.
- busy = (state == SEND).
- Arithmetic:
  - rem is LEN_W bits.
  - Beats per packet = ceil(cmd_len / DATA_BYTES).
  - cmd_len = 2^LEN_W - 1 must work with no overflow.
- Reset during SEND: packet is abandoned immediately. tvalid=0 in the same cycle (async), with no tlast emitted.
- cmd_valid held high while busy: the command waits; it is not captured until back in IDLE.

Test Plan:
- DATA_BYTES=8, cmd_len=20, seed=0x10, tready=1 → 3 beats with tkeep 0xFF, 0xFF, 0x0F; tlast only on beat 3; bytes 0x10..0x27 in order; first tvalid 1 cycle after command; pkt_cnt=1.
- cmd_len=8, then cmd_len=1 → single beat with tkeep=0xFF and tlast=1; then single beat with tkeep=0x01, tlast=1, byte0=seed. Verify the 1-cycle idle gap between the packets.
- cmd_len=24, seed=0xFE, random tready (50%) → bytes wrap 0xFE, 0xFF, 0x00…; beat fields stable during stalls; tvalid never drops early; 3 beats, all tkeep=0xFF.
- cmd_len=0 with cmd_valid=1 → no tvalid, cmd_ready stays 1, pkt_cnt unchanged.
- Second cmd_valid asserted during SEND → cmd_ready=0 until the final handshake; the second packet starts 1 cycle after the return to IDLE.
- reset_n pulsed low on beat 2 of a 40-byte packet → all outputs reach their reset values asynchronously; a new command after reset produces a correct packet and pkt_cnt=1.
